riscv_v_xor_unit: RTL and testbench

Pipelined, parametrised successor of the vector bitwise-XOR datapath in the RISC-V V execution cluster. Executes element-wise XOR, mask-register XOR/XNOR and ordered XOR reduction (vredxor) over multi-beat register groups (LMUL > 1), with a valid/ready handshake on both sides. Sits between the vector operand-read stage and the writeback arbiter. Sustains one beat per cycle.

---
 rtl/riscv_v_xor_unit_pkg.sv | 42 ++++
 rtl/riscv_v_xor_unit_fold.sv | 45 ++++
 rtl/riscv_v_xor_unit.sv | 152 +++++++++++++++
 tb/tb_riscv_v_xor_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_xor_unit_pkg.sv
// Shared encodings and helpers for the vector XOR datapath: op codes,
// element-size indices and the one-hot element-size cleanup rule.
package riscv_v_xor_unit_pkg;

  localparam int RISCV_V_NUM_VALID_OSIZES = 5;

  localparam logic [1:0] RISCV_V_XOR_OP_VXOR    = 2'b00;
  localparam logic [1:0] RISCV_V_XOR_OP_VREDXOR = 2'b01;
  localparam logic [1:0] RISCV_V_XOR_OP_VMXOR   = 2'b10;
  localparam logic [1:0] RISCV_V_XOR_OP_VMXNOR  = 2'b11;

  localparam int OSIZE_8   = 0;
  localparam int OSIZE_16  = 1;
  localparam int OSIZE_32  = 2;
  localparam int OSIZE_64  = 3;
  localparam int OSIZE_128 = 4;

  typedef logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize_t;

  localparam osize_t OSIZE_ONEHOT_8   = osize_t'(1) << OSIZE_8;
  localparam osize_t OSIZE_ONEHOT_128 = osize_t'(1) << OSIZE_128;

  // Isolate the lowest set bit; an empty vector means 8-bit elements.
  function automatic osize_t osize_onehot_to_bits(input osize_t osize);
    osize_t r;
    r = osize & (~osize + osize_t'(1));
    if (r == '0) r = OSIZE_ONEHOT_8;
    return r;
  endfunction

  // Low-bit mask covering one element of the given (clean) size.
  function automatic logic [127:0] osize_low_mask(input osize_t oh);
    logic [127:0] m;
    m = '1;
    if (oh[OSIZE_8])       m = {{120{1'b0}}, {8{1'b1}}};
    else if (oh[OSIZE_16]) m = {{112{1'b0}}, {16{1'b1}}};
    else if (oh[OSIZE_32]) m = {{96{1'b0}}, {32{1'b1}}};
    else if (oh[OSIZE_64]) m = {{64{1'b0}}, {64{1'b1}}};
    return m;
  endfunction

endpackage

// File: rtl/riscv_v_xor_unit_fold.sv
// Combinational XOR fold: masked bytes of a beat are XORed down to one
// element of the requested size; bits above that size read as zero.
module riscv_v_xor_fold
  import riscv_v_xor_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [NUM_BYTES-1:0]  mask,
  input  osize_t                osize,
  output logic [127:0]          folded
);

  localparam int NUM_CHUNKS = DATA_WIDTH / 128;

  logic [127:0] f128;
  logic [63:0]  f64;
  logic [31:0]  f32;
  logic [15:0]  f16;
  logic [7:0]   f8;
  osize_t       oh;

  always_comb begin
    f128 = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      for (int b = 0; b < 16; b++) begin
        if (mask[c*16+b]) f128[b*8 +: 8] = f128[b*8 +: 8] ^ data[c*128 + b*8 +: 8];
      end
    end
    // Halving cascade: each narrower element is the XOR of the two halves above it.
    f64 = f128[63:0] ^ f128[127:64];
    f32 = f64[31:0] ^ f64[63:32];
    f16 = f32[15:0] ^ f32[31:16];
    f8  = f16[7:0] ^ f16[15:8];
    oh  = osize_onehot_to_bits(osize);
    folded = '0;
    if (oh[OSIZE_8])       folded[7:0]  = f8;
    else if (oh[OSIZE_16]) folded[15:0] = f16;
    else if (oh[OSIZE_32]) folded[31:0] = f32;
    else if (oh[OSIZE_64]) folded[63:0] = f64;
    else                   folded       = f128;
  end

endmodule

// File: rtl/riscv_v_xor_unit.sv
// Two-stage vector XOR unit: element-wise vxor, mask vmxor/vmxnor and the
// ordered vredxor reduction across multi-beat register groups.
module riscv_v_xor_unit
  import riscv_v_xor_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_BYTES  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [4:0]            in_osize,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_srca,
  input  logic [DATA_WIDTH-1:0] in_srcb,
  input  logic [NUM_BYTES-1:0]  in_vmask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_last,
  output logic                  seq_err
);

  // Handshake: a beat moves on a side exactly when that side's valid and
  // ready are both high at the clock edge; valid never waits on ready.
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_red;
  logic                  s1_first;
  logic                  s1_last;
  osize_t                s1_osize;

  logic                  grp_open;
  osize_t                grp_osize;
  logic [127:0]          acc;

  logic                  s1_adv;
  logic                  accept;
  logic                  in_red;
  osize_t                in_osize_eff;
  logic [127:0]          in_fold;
  logic [127:0]          red_init;
  logic [DATA_WIDTH-1:0] s1_d;
  logic [127:0]          acc_next;
  logic [127:0]          s2_fold;
  logic [DATA_WIDTH-1:0] s2_res;

  assign s1_adv       = !out_valid || out_ready;
  assign in_ready     = !rst && (!s1_valid || s1_adv);
  assign accept       = in_valid && in_ready;
  assign in_red       = (in_op == RISCV_V_XOR_OP_VREDXOR);
  assign in_osize_eff = (in_red && !in_first) ? grp_osize : osize_onehot_to_bits(in_osize);

  riscv_v_xor_fold #(.DATA_WIDTH(DATA_WIDTH)) u_fold_s1 (
    .data   (in_srca),
    .mask   (in_vmask),
    .osize  (OSIZE_ONEHOT_128),
    .folded (in_fold)
  );

  // Reduction beats carry their 128-bit partial fold (plus the vs1 seed on
  // the first beat); the narrowing to osize happens once, at the output.
  always_comb begin
    red_init = in_first ? (in_srcb[127:0] & osize_low_mask(in_osize_eff)) : '0;
    s1_d = in_srca ^ in_srcb;
    case (in_op)
      RISCV_V_XOR_OP_VXOR: begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (!in_vmask[i]) s1_d[i*8 +: 8] = in_srca[i*8 +: 8];
        end
      end
      RISCV_V_XOR_OP_VMXNOR: s1_d = ~(in_srca ^ in_srcb);
      RISCV_V_XOR_OP_VREDXOR: begin
        s1_d = '0;
        s1_d[127:0] = in_fold ^ red_init;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_red    <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_osize  <= OSIZE_ONEHOT_8;
      grp_open  <= 1'b0;
      grp_osize <= OSIZE_ONEHOT_8;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= accept && grp_open && (!in_red || in_first);
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_data  <= s1_d;
          s1_red   <= in_red;
          s1_first <= in_first;
          s1_last  <= in_last;
          s1_osize <= in_osize_eff;
        end
      end
      if (accept && in_red) begin
        grp_open <= !in_last;
        if (in_first) grp_osize <= in_osize_eff;
      end
    end
  end

  // A first beat reseeds acc, which also discards any abandoned partial group.
  assign acc_next = s1_first ? s1_data[127:0] : (acc ^ s1_data[127:0]);

  riscv_v_xor_fold #(.DATA_WIDTH(128)) u_fold_s2 (
    .data   (acc_next),
    .mask   ({16{1'b1}}),
    .osize  (s1_osize),
    .folded (s2_fold)
  );

  always_comb begin
    s2_res = '0;
    s2_res[127:0] = s2_fold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_last   <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= s1_valid && (!s1_red || s1_last);
      if (s1_valid) begin
        if (s1_red) begin
          acc <= acc_next;
          if (s1_last) begin
            out_result <= s2_res;
            out_last   <= 1'b1;
          end
        end else begin
          out_result <= s1_data;
          out_last   <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_v_xor_unit.sv
// Directed bench for riscv_v_xor_unit: vector table plus hand-written
// multi-beat reduction, stall, sequencing-error and reset sequences.
module tb_riscv_v_xor_unit;
  import riscv_v_xor_unit_pkg::*;

  localparam int DW = 128;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [4:0]    in_osize = '0;
  logic          in_first = 1'b0;
  logic          in_last = 1'b0;
  logic [DW-1:0] in_srca = '0;
  logic [DW-1:0] in_srcb = '0;
  logic [NB-1:0] in_vmask = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_result;
  logic          out_last;
  logic          seq_err;

  riscv_v_xor_unit #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_osize(in_osize), .in_first(in_first), .in_last(in_last), .in_srca(in_srca),
    .in_srcb(in_srcb), .in_vmask(in_vmask), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_last(out_last), .seq_err(seq_err)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_cnt = 0;
  int seq_cnt = 0;
  bit rand_rdy = 1'b0;
  logic was_stalled = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete (errors so far %0d)", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      was_stalled = 1'b0;
    end else begin
      if (seq_err) seq_cnt++;
      if (was_stalled) chk_bit("hold_valid", out_valid, 1'b1);
      if (exp_q.size() == 0) begin
        chk_bit("spurious_out", out_valid, 1'b0);
      end else if (out_valid) begin
        chk("out_result", out_result, exp_q[0]);
        chk_bit("out_last", out_last, exp_last_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_last_q.pop_front());
          out_cnt++;
        end
      end
      was_stalled = out_valid && !out_ready;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_out(input logic [DW-1:0] res, input logic last);
    exp_q.push_back(res);
    exp_last_q.push_back(last);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [4:0] osz, input logic first,
                      input logic last, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [NB-1:0] m);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_osize = osz; in_first = first; in_last = last;
    in_srca = a; in_srcb = b; in_vmask = m;
    do begin
      @(negedge clk);
      ok = in_ready;
      n++;
    end while (!ok && n < 100);
    if (!ok) chk_bit("accept_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_int("drain_timeout", exp_q.size(), 0);
  endtask

  function automatic logic [DW-1:0] vxor_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [NB-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) r[i*8 +: 8] = m[i] ? (a[i*8 +: 8] ^ b[i*8 +: 8]) : a[i*8 +: 8];
    return r;
  endfunction

  typedef struct {
    logic [1:0]    op;
    logic [4:0]    osize;
    logic          first;
    logic          last;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [NB-1:0] m;
    logic [DW-1:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] osz, input logic first,
                              input logic last, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [NB-1:0] m, input logic [DW-1:0] exp);
    vec_t v;
    v.op = op; v.osize = osz; v.first = first; v.last = last;
    v.a = a; v.b = b; v.m = m; v.exp = exp;
    return v;
  endfunction

  localparam logic [1:0] VX  = RISCV_V_XOR_OP_VXOR;
  localparam logic [1:0] VR  = RISCV_V_XOR_OP_VREDXOR;
  localparam logic [1:0] VMX = RISCV_V_XOR_OP_VMXOR;
  localparam logic [1:0] VMN = RISCV_V_XOR_OP_VMXNOR;

  vec_t tbl[13];

  // ---------------- test sequence ----------------
  initial begin
    int t0, o0, s0;
    logic [DW-1:0] a, b;
    logic [NB-1:0] m;

    tbl[0]  = mk(VR,  5'b00100, 1, 1, 128'h00000008_00000004_00000002_00000001, 128'h10, 16'hFFFF, 128'h1F);
    tbl[1]  = mk(VMX, 5'b00001, 1, 1, {16{8'hF0}}, {8{16'h0FF0}}, 16'h0000, {8{16'hFF00}});
    tbl[2]  = mk(VMN, 5'b00001, 1, 1, 128'h0123456789abcdef_fedcba9876543210,
                 128'h0123456789abcdef_fedcba9876543210, 16'hFFFF, {128{1'b1}});
    tbl[3]  = mk(VX,  5'b00001, 0, 0, 128'h0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 16'hFFFF,
                 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    tbl[4]  = mk(VX,  5'b00001, 1, 1, {16{8'h11}}, {16{8'hFF}}, 16'h0000, {16{8'h11}});
    tbl[5]  = mk(VR,  5'b00001, 1, 1, 128'h100F0E0D0C0B0A09_0807060504030201, 128'h0, 16'hFFFF, 128'h10);
    tbl[6]  = mk(VR,  5'b00001, 1, 1, 128'h100F0E0D0C0B0A09_0807060504030201,
                 128'hEEEEEEEEEEEEEEEE_EEEEEEEEEEEEEE03, 16'h000F, 128'h07);
    tbl[7]  = mk(VR,  5'b00010, 1, 1, {8{16'h1234}}, 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFBEEF, 16'hFFFF, 128'hBEEF);
    tbl[8]  = mk(VR,  5'b01000, 1, 1, 128'hFFFF0000FFFF0000_0000FFFF0000FFFF, 128'h0, 16'hFFFF,
                 128'h0000000000000000_FFFFFFFFFFFFFFFF);
    tbl[9]  = mk(VR,  5'b10000, 1, 1, {128{1'b1}}, 128'h8000000000000000_0000000000000001, 16'h00FF,
                 128'h8000000000000000_FFFFFFFFFFFFFFFE);
    tbl[10] = mk(VR,  5'b00110, 1, 1, 128'h00F0000F, 128'h0, 16'hFFFF, 128'hFF);
    tbl[11] = mk(VR,  5'b00000, 1, 1, 128'h0302, 128'h0, 16'hFFFF, 128'h01);
    tbl[12] = mk(VR,  5'b11111, 1, 1, 128'h0302, 128'h0100, 16'hFFFF, 128'h01);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_bit("post_rst_in_ready", in_ready, 1'b1);
    chk_bit("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_out_result", out_result, '0);
    chk_bit("post_rst_out_last", out_last, 1'b0);
    chk_bit("post_rst_seq_err", seq_err, 1'b0);
    @(posedge clk);
    #1;

    // vxor with latency check: accepted in N, valid in N+2
    expect_out(128'hAAAAAAAAAAAAAAAA_A5A5A5A5A5A5A5A5, 1'b1);
    send(VX, 5'b00001, 1, 1, {16{8'hAA}}, {16{8'h0F}}, 16'h00FF);
    @(negedge clk);
    chk_bit("latency_n1", out_valid, 1'b0);
    @(negedge clk);
    chk_bit("latency_n2", out_valid, 1'b1);
    @(posedge clk);
    #1;
    wait_drain();

    // Vector table
    s0 = seq_cnt;
    for (int i = 0; i < 13; i++) begin
      expect_out(tbl[i].exp, tbl[i].last);
      send(tbl[i].op, tbl[i].osize, tbl[i].first, tbl[i].last, tbl[i].a, tbl[i].b, tbl[i].m);
    end
    wait_drain();
    chk_int("table_seq_err", seq_cnt - s0, 0);

    // vmxnor with equal random operands
    a = {$urandom, $urandom, $urandom, $urandom};
    expect_out({128{1'b1}}, 1'b1);
    send(VMN, 5'b00001, 1, 1, a, a, 16'h0000);
    wait_drain();

    // 4-beat 8-bit reduction, output stalled for 3 cycles on the last beat
    o0 = out_cnt;
    send(VR, 5'b00001, 1, 0, 128'h01, {{15{8'hAB}}, 8'hFF}, 16'hFFFF);
    send(VR, 5'b10000, 0, 0, 128'h01, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    send(VR, 5'b10000, 0, 0, 128'h01, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    out_ready = 1'b0;
    expect_out(128'hFF, 1'b1);
    send(VR, 5'b10000, 0, 1, 128'h01, {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    @(negedge clk);
    @(negedge clk);
    chk_bit("stall_valid", out_valid, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();
    chk_int("stall_single_output", out_cnt - o0, 1);

    // osize held from the first beat of a group
    expect_out(128'h0300, 1'b1);
    send(VR, 5'b00010, 1, 0, 128'h0100, 128'h0, 16'hFFFF);
    send(VR, 5'b00001, 0, 1, 128'h0200, 128'h0, 16'hFFFF);
    wait_drain();

    // Throughput: 20 back-to-back vxor beats with out_ready high
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      m = 16'($urandom);
      expect_out(vxor_model(a, b, m), 1'(i == 19));
      send(VX, 5'b00001, 1'(i == 0), 1'(i == 19), a, b, m);
    end
    chk_int("throughput_cycles", cyc - t0, 20);
    wait_drain();

    // 20 vxor beats with random out_ready
    o0 = out_cnt;
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      m = 16'($urandom);
      expect_out(vxor_model(a, b, m), 1'b1);
      send(VX, 5'b00001, 1, 1, a, b, m);
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk_int("random_ready_count", out_cnt - o0, 20);

    // Second in_first mid-group, then a non-reduction op inside the open group
    o0 = out_cnt;
    s0 = seq_cnt;
    send(VR, 5'b00001, 1, 0, 128'h05, 128'h00, 16'hFFFF);
    send(VR, 5'b00001, 1, 0, 128'h10, 128'h20, 16'hFFFF);
    @(negedge clk);
    chk_bit("seq_err_restart", seq_err, 1'b1);
    @(posedge clk);
    #1;
    expect_out(128'hFF, 1'b1);
    send(VX, 5'b00001, 1, 1, 128'h0F, 128'hF0, 16'h0001);
    @(negedge clk);
    chk_bit("seq_err_nonred", seq_err, 1'b1);
    @(posedge clk);
    #1;
    expect_out(128'h31, 1'b1);
    send(VR, 5'b00001, 0, 1, 128'h01, 128'h00, 16'hFFFF);
    wait_drain();
    chk_int("seq_err_count", seq_cnt - s0, 2);
    chk_int("seq_output_count", out_cnt - o0, 2);

    // Reset in the middle of a reduction group
    o0 = out_cnt;
    s0 = seq_cnt;
    send(VR, 5'b00001, 1, 0, 128'h05, 128'h00, 16'hFFFF);
    send(VR, 5'b00001, 0, 0, 128'h07, 128'h00, 16'hFFFF);
    rst = 1'b1;
    @(negedge clk);
    chk_bit("mid_rst_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_bit("after_rst_in_ready", in_ready, 1'b1);
    chk_bit("after_rst_out_valid", out_valid, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk_int("after_rst_no_output", out_cnt - o0, 0);
    expect_out(128'h42, 1'b1);
    send(VR, 5'b00001, 1, 1, 128'h42, 128'h00, 16'hFFFF);
    wait_drain();
    chk_int("after_rst_seq_err", seq_cnt - s0, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
